// File: rtl/decoder_scan_if.sv
// rtl/decoder_scan_if.sv - Handshake and data bundle between a controller and decoder_scan.
//
// master: controller side, drives en/mode/in_valid/in_sel/mask and observes the decoder outputs.
// slave : decoder side, drives in_ready/out/out_valid/scan_idx/wrap.
interface decoder_scan_if #(
    parameter int SEL_W = 3
) ();
    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic             in_valid;
    logic [SEL_W-1:0] in_sel;
    logic             in_ready;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [SEL_W-1:0] scan_idx;
    logic             wrap;

    modport master (
        output en, mode, in_valid, in_sel, mask,
        input  in_ready, out, out_valid, scan_idx, wrap
    );

    modport slave (
        input  en, mode, in_valid, in_sel, mask,
        output in_ready, out, out_valid, scan_idx, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - Registered one-hot decoder with direct ready/valid mode and masked scan mode.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   bus (slave)    en/mode/in_valid/in_sel/mask in; in_ready (comb), out/out_valid/scan_idx/wrap (registered) out
// Parameters: SEL_W select width (OUT_W = 2**SEL_W), DWELL cycles per scanned channel,
//             ACTIVE_LOW inverts every out bit after the register.
module decoder_scan #(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    decoder_scan_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN, SCAN_EMPTY} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] hot_q, hot_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] low_idx;
    logic [SEL_W-1:0] next_idx;
    logic [SEL_W-1:0] probe;
    logic             mask_any;

    assign mask_any     = |bus.mask;
    assign bus.in_ready = bus.en & ~bus.mode;

    // Polarity is applied after the register so the inactive level is correct even in reset.
    assign bus.out       = hot_q ^ {OUT_W{ACTIVE_LOW}};
    assign bus.out_valid = out_valid_q;
    assign bus.scan_idx  = scan_idx_q;
    assign bus.wrap      = wrap_q;

    // Lowest set mask bit, and the next set bit strictly above scan_idx rotating modulo OUT_W.
    // Iterating from the farthest offset down lets the nearest match win; offset OUT_W lands
    // back on scan_idx itself, which covers the single-channel case.
    always_comb begin
        low_idx  = '0;
        next_idx = scan_idx_q;
        probe    = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            if (bus.mask[i]) low_idx = SEL_W'(i);
        end
        for (int i = OUT_W; i >= 1; i--) begin
            probe = scan_idx_q + SEL_W'(i);
            if (bus.mask[probe]) next_idx = probe;
        end
    end

    always_comb begin
        state_d     = state_q;
        hot_d       = hot_q;
        out_valid_d = out_valid_q;
        scan_idx_d  = scan_idx_q;
        wrap_d      = 1'b0;
        cnt_d       = cnt_q;
        if (!bus.en) begin
            state_d     = IDLE;
            hot_d       = '0;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else if (!bus.mode) begin
            cnt_d = '0;
            if (state_q == SCAN || state_q == SCAN_EMPTY) begin
                state_d     = IDLE;
                hot_d       = '0;
                out_valid_d = 1'b0;
            end
            // A decode on the same edge that leaves scan overrides the blanking above.
            if (bus.in_valid) begin
                state_d     = DIRECT;
                hot_d       = OUT_W'(1) << bus.in_sel;
                scan_idx_d  = bus.in_sel;
                out_valid_d = 1'b1;
            end
        end else begin
            case (state_q)
                SCAN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!mask_any) begin
                            state_d     = SCAN_EMPTY;
                            hot_d       = '0;
                            out_valid_d = 1'b0;
                        end else begin
                            scan_idx_d = next_idx;
                            hot_d      = OUT_W'(1) << next_idx;
                            wrap_d     = (next_idx <= scan_idx_q);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // Scan entry from IDLE/DIRECT and re-entry from SCAN_EMPTY; never a wrap.
                    cnt_d = '0;
                    if (mask_any) begin
                        state_d     = SCAN;
                        scan_idx_d  = low_idx;
                        hot_d       = OUT_W'(1) << low_idx;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = SCAN_EMPTY;
                        hot_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hot_q       <= '0;
            out_valid_q <= 1'b0;
            scan_idx_q  <= '0;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hot_q       <= hot_d;
            out_valid_q <= out_valid_d;
            scan_idx_q  <= scan_idx_d;
            wrap_q      <= wrap_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - Directed table-driven bench for decoder_scan.
module tb_decoder_scan;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(3)) m_if ();
    decoder_scan_if #(.SEL_W(3)) al_if ();
    decoder_scan_if #(.SEL_W(1)) s1_if ();
    decoder_scan_if #(.SEL_W(4)) s4_if ();
    decoder_scan_if #(.SEL_W(6)) s6_if ();

    assign al_if.en       = m_if.en;
    assign al_if.mode     = m_if.mode;
    assign al_if.in_valid = m_if.in_valid;
    assign al_if.in_sel   = m_if.in_sel;
    assign al_if.mask     = m_if.mask;

    decoder_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    decoder_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b1)) u_al   (.clk(clk), .rst_n(rst_n), .bus(al_if.slave));
    decoder_scan #(.SEL_W(1), .DWELL(1), .ACTIVE_LOW(1'b0)) u_s1   (.clk(clk), .rst_n(rst_n), .bus(s1_if.slave));
    decoder_scan #(.SEL_W(4), .DWELL(1), .ACTIVE_LOW(1'b0)) u_s4   (.clk(clk), .rst_n(rst_n), .bus(s4_if.slave));
    decoder_scan #(.SEL_W(6), .DWELL(1), .ACTIVE_LOW(1'b0)) u_s6   (.clk(clk), .rst_n(rst_n), .bus(s6_if.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [7:0] e_out, input logic e_valid,
                            input logic [2:0] e_idx, input logic e_wrap);
        chk({tag, ".out"},       64'(m_if.out),       64'(e_out));
        chk({tag, ".out_al"},    64'(al_if.out),      64'(e_out ^ 8'hFF));
        chk({tag, ".out_valid"}, 64'(m_if.out_valid), 64'(e_valid));
        chk({tag, ".scan_idx"},  64'(m_if.scan_idx),  64'(e_idx));
        chk({tag, ".wrap"},      64'(m_if.wrap),      64'(e_wrap));
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic       in_valid;
        logic [2:0] in_sel;
        logic [7:0] e_out;
        logic       e_valid;
        logic [2:0] e_idx;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [2:0] lst [4];
        logic [2:0] e_idx;
        lst[0] = 3'd0; lst[1] = 3'd2; lst[2] = 3'd5; lst[3] = 3'd7;

        // Direct-mode vectors, applied starting from IDLE with en low.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            tbl[k + 1] = '{1'b1, 1'b0, 1'b1, 3'(k), 8'(1 << k), 1'b1, 3'(k), 1'b1};
        end
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h80, 1'b1, 3'd7, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 3'd7, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 3'd7, 1'b0};

        rst_n = 1'b0;
        m_if.en = 1'b0; m_if.mode = 1'b0; m_if.in_valid = 1'b0; m_if.in_sel = '0; m_if.mask = '0;
        s1_if.en = 1'b0; s1_if.mode = 1'b0; s1_if.in_valid = 1'b0; s1_if.in_sel = '0; s1_if.mask = '1;
        s4_if.en = 1'b0; s4_if.mode = 1'b0; s4_if.in_valid = 1'b0; s4_if.in_sel = '0; s4_if.mask = '1;
        s6_if.en = 1'b0; s6_if.mode = 1'b0; s6_if.in_valid = 1'b0; s6_if.in_sel = '0; s6_if.mask = '1;

        tick(); tick();
        chk_main("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_main("release", 8'h00, 1'b0, 3'd0, 1'b0);

        foreach (tbl[i]) begin
            m_if.en = tbl[i].en; m_if.mode = tbl[i].mode;
            m_if.in_valid = tbl[i].in_valid; m_if.in_sel = tbl[i].in_sel;
            #1;
            chk($sformatf("vec%0d.in_ready", i), 64'(m_if.in_ready), 64'(tbl[i].e_rdy));
            tick();
            chk_main($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_valid, tbl[i].e_idx, 1'b0);
        end

        // Scan over mask 1010_0101: 0,2,5,7 each held 4 cycles, wrap on 7->0.
        m_if.en = 1'b1; m_if.mode = 1'b1; m_if.in_valid = 1'b0; m_if.mask = 8'hA5;
        #1;
        chk("scan.in_ready", 64'(m_if.in_ready), 64'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            e_idx = lst[(k / 4) % 4];
            chk_main($sformatf("scan%0d", k), 8'(1 << e_idx), 1'b1, e_idx, k == 16);
        end

        // Single enabled channel, then empty mask, then re-entry.
        m_if.en = 1'b0;
        tick();
        chk_main("single.off", 8'h00, 1'b0, 3'd0, 1'b0);
        m_if.en = 1'b1; m_if.mask = 8'h10;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk_main($sformatf("single%0d", k), 8'h10, 1'b1, 3'd4, (k == 4) || (k == 8));
        end
        m_if.mask = 8'h00;
        for (int k = 9; k < 12; k++) begin
            tick();
            chk_main($sformatf("drain%0d", k), 8'h10, 1'b1, 3'd4, 1'b0);
        end
        tick();
        chk_main("empty", 8'h00, 1'b0, 3'd4, 1'b0);
        tick();
        chk_main("empty.hold", 8'h00, 1'b0, 3'd4, 1'b0);
        m_if.mask = 8'h03;
        tick();
        chk_main("reenter", 8'h01, 1'b1, 3'd0, 1'b0);
        tick();
        chk_main("reenter.dwell", 8'h01, 1'b1, 3'd0, 1'b0);

        // Leaving scan mid-dwell with a simultaneous decode request.
        m_if.mode = 1'b0; m_if.in_valid = 1'b1; m_if.in_sel = 3'd6;
        #1;
        chk("leave.in_ready", 64'(m_if.in_ready), 64'd1);
        tick();
        chk_main("leave.direct", 8'h40, 1'b1, 3'd6, 1'b0);

        // Leaving scan without a decode request blanks the output.
        m_if.mode = 1'b1; m_if.in_valid = 1'b0;
        tick();
        chk_main("scan2.enter", 8'h01, 1'b1, 3'd0, 1'b0);
        m_if.mode = 1'b0;
        tick();
        chk_main("scan2.leave", 8'h00, 1'b0, 3'd0, 1'b0);

        // Dropping en mid-scan.
        m_if.mode = 1'b1; m_if.mask = 8'hA5;
        tick(); tick();
        chk_main("en.mid", 8'h01, 1'b1, 3'd0, 1'b0);
        m_if.en = 1'b0;
        tick();
        chk_main("en.drop", 8'h00, 1'b0, 3'd0, 1'b0);

        // Reset mid-scan while on channel 2.
        m_if.en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk_main("rst.pre", 8'h04, 1'b1, 3'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_main("rst.mid", 8'h00, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1; m_if.en = 1'b0; m_if.mode = 1'b0;
        tick();

        // DWELL=1 sweeps with all channels enabled.
        s1_if.en = 1'b1; s1_if.mode = 1'b1;
        s4_if.en = 1'b1; s4_if.mode = 1'b1;
        s6_if.en = 1'b1; s6_if.mode = 1'b1;
        for (int k = 0; k <= 128; k++) begin
            tick();
            chk($sformatf("s1.idx%0d", k),  64'(s1_if.scan_idx), 64'(k % 2));
            chk($sformatf("s1.wrap%0d", k), 64'(s1_if.wrap),     64'((k > 0) && (k % 2 == 0)));
            chk($sformatf("s4.idx%0d", k),  64'(s4_if.scan_idx), 64'(k % 16));
            chk($sformatf("s4.out%0d", k),  64'(s4_if.out),      64'(1) << (k % 16));
            chk($sformatf("s4.wrap%0d", k), 64'(s4_if.wrap),     64'((k > 0) && (k % 16 == 0)));
            chk($sformatf("s6.idx%0d", k),  64'(s6_if.scan_idx), 64'(k % 64));
            chk($sformatf("s6.out%0d", k),  64'(s6_if.out),      64'(1) << (k % 64));
            chk($sformatf("s6.wrap%0d", k), 64'(s6_if.wrap),     64'((k > 0) && (k % 64 == 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a ready/valid input, a selectable active-low output polarity, and an autonomous masked scan mode. In scan mode, the output walks across the enabled channels with a programmable dwell. It sits between control logic and multiplexed loads such as display digit/row strobes, chip selects and channel enables. It is the clocked, multi-mode generation of the combinational 3-to-8 decoder.

## Interface
- SEL_W, 3, select width; OUT_W = 2**SEL_W outputs (SEL_W 1..6)
- DWELL, 4, clock cycles each channel is held in scan mode (>=1)
- ACTIVE_LOW, 0, 1 inverts every bit of out (inactive level = all ones)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  block enable; low forces out inactive
- mode  in  1  0 = direct decode, 1 = scan
- in_valid  in  1  in_sel valid (direct mode)
- in_sel  in  SEL_W  channel to assert
- in_ready  out  1  combinational: en & ~mode
- mask  in  OUT_W  scan enable per channel (1 = included)
- out  out  OUT_W  registered one-hot (polarity per ACTIVE_LOW)
- out_valid  out  1  out currently drives a channel
- scan_idx  out  SEL_W  registered index of the asserted channel
- wrap  out  1  one-cycle pulse when scan passes the top enabled channel back to a lower-or-equal one

## Operation
- Reset (rst_n low at an edge): state IDLE, out inactive (0s, or 1s if ACTIVE_LOW), out_valid 0, scan_idx 0, wrap 0, dwell counter 0. Reset mid-scan aborts immediately.
- States: IDLE, DIRECT, SCAN, SCAN_EMPTY.
- en low at any edge: go to IDLE, out inactive, out_valid 0, wrap 0. This has priority over mode and in_valid.
- DIRECT / IDLE with mode=0:
  - Accept = en & ~mode & in_valid.
  - On accept, out <= onehot(in_sel), scan_idx <= in_sel, out_valid <= 1, state DIRECT.
  - Without accept, out holds its last value. There is no back-pressure beyond en/mode.
- Entering scan (mode=1 sampled with en=1 from IDLE/DIRECT):
  - If mask != 0, go to SCAN with scan_idx <= lowest set mask bit, out <= its one-hot, out_valid 1, dwell counter <= 0.
  - If mask == 0, go to SCAN_EMPTY.
- SCAN:
  - The dwell counter increments each cycle.
  - When it equals DWELL-1: counter <= 0, scan_idx <= next set mask bit strictly above scan_idx, wrapping modulo OUT_W, and out follows.
  - If the chosen index is <= the current one, wrap pulses 1 for that cycle.
  - Only one bit set: the block re-selects the same channel and pulses wrap every DWELL cycles.
  - mask is sampled only at advance points. Clearing the current channel's bit mid-dwell does not shorten the dwell.
  - At an advance point with mask == 0, go to SCAN_EMPTY.
- SCAN_EMPTY: out inactive, out_valid 0, scan_idx holds. When mask becomes nonzero, enter SCAN at the lowest set bit on the next edge with the dwell restarted. No wrap is generated on this re-entry.
- Leaving scan (mode=0 sampled): out inactive, out_valid 0, state IDLE on that edge. A simultaneous in_valid is accepted, because in_ready is already 1. In that case DIRECT decode wins and out <= onehot(in_sel).
- Arithmetic: dwell counter is clog2(DWELL) bits wide (min 1). The next-channel search is a rotate-priority scan over OUT_W bits. Index wrap is modulo OUT_W.

## Timing
- Direct latency: 1 cycle. An accept at edge t drives out at t (registered), visible from t+1 sampling. Back-to-back accepts update every cycle.
- Scan: the first channel is asserted on the edge that samples mode=1. Each channel is then held exactly DWELL cycles. The full period equals DWELL × popcount(mask).
- wrap is coincident with the out update to the wrapped-to channel and lasts 1 cycle.
- in_ready is combinational from en/mode. out, out_valid, scan_idx and wrap are all registered.
- Output polarity inversion applies after the register, i.e. it is a registered value XOR ACTIVE_LOW. The inactive level always follows ACTIVE_LOW, including during reset.

## Test plan
- Reset/polarity: hold rst_n=0 with ACTIVE_LOW=0 and 1 → out = 8'h00 / 8'hFF, out_valid 0, scan_idx 0. Release rst_n with en=0 → outputs unchanged.
- Direct sweep (SEL_W=3): en=1, mode=0, in_sel 0..7 with in_valid every cycle → out 8'h01, 8'h02 … 8'h80, each one cycle after accept. in_valid=0 → out holds 8'h80.
- Scan with mask=8'b1010_0101, DWELL=4 → scan_idx sequence 0,2,5,7,0 with each held 4 cycles. wrap pulses on the 7→0 step only, and the period is 16 cycles.
- Single-bit and empty mask: mask=8'h10 → out 8'h10 continuous, wrap every 4 cycles. Change the mask to 0 → SCAN_EMPTY at the next advance, out 0, out_valid 0. Set mask=8'h03 → scan_idx 0 on the next edge with no wrap.
- Mode/enable interactions: mid-dwell, drop mode with in_valid=1, in_sel=6 → out 8'h40 next edge. Drop en mid-scan → out 0 next edge. Assert rst_n=0 mid-scan → full reset values next edge.
- Parameter sweep: SEL_W=1, 4, 6 with DWELL=1 and mask all ones → scan_idx increments every cycle, and wrap pulses once per OUT_W cycles.
